// File: rtl/wb_cmd_sequencer_if.sv
// Wishbone classic bus bundle between the command sequencer (master) and
// the on-chip interconnect (slave).
//   wb_cyc_o / wb_stb_o / wb_we_o : cycle, strobe, write enable (master out)
//   wb_adr_o / wb_dat_o / wb_sel_o: byte address, write data, byte selects
//   wb_dat_i / wb_ack_i / wb_err_i: read data, acknowledge, error (slave out)
interface wb_cmd_sequencer_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_cmd_sequencer.sv
// Executes 34-bit host command words as single Wishbone classic transfers,
// returns read data / error markers as ASCII bytes to the UART transmitter
// and generates the soft-reset pulse.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cmd_i[33:0]     : [33:32] opcode (00 R, 01 W, 10 A, 11 S), [31:0] argument
//   cmd_valid_i     : single-cycle command strobe
//   cmd_drop_o      : pulse, a command arrived while busy and was discarded
//   busy_o          : high whenever not idle
//   wb              : Wishbone master modport
//   tx_data_o       : byte to transmitter, held until the next load
//   tx_start_o      : single-cycle load pulse
//   tx_busy_i       : transmitter busy
//   srst_o          : active-high soft-reset pulse
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command; A commands complete here
// BUS       | Wishbone cycle in flight, timeout counter running
// RESP_LOAD | waiting for transmitter idle, then load the next byte
// RESP_WAIT | byte loaded; skip one cycle, then wait for busy to fall
// SRST      | srst_o asserted for SRST_CYCLES cycles
module wb_cmd_sequencer #(
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SRST_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [33:0]         cmd_i,
  input  logic                cmd_valid_i,
  output logic                cmd_drop_o,
  output logic                busy_o,
  wb_cmd_sequencer_if.master  wb,
  output logic [7:0]          tx_data_o,
  output logic                tx_start_o,
  input  logic                tx_busy_i,
  output logic                srst_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (SRST_CYCLES < 2) ? 1 : $clog2(SRST_CYCLES + 1);

  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [SW-1:0] SRST_LOAD = SW'(SRST_CYCLES - 1);
  localparam logic [31:0]   STEP      = 32'(ADDR_STEP);

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_A = 2'b10;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BUS       = 3'd1;
  localparam logic [2:0] S_RESP_LOAD = 3'd2;
  localparam logic [2:0] S_RESP_WAIT = 3'd3;
  localparam logic [2:0] S_SRST      = 3'd4;

  logic [2:0]    state;
  logic [31:0]   addr;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] srst_cnt;
  logic [31:0]   rd_data;
  logic          resp_err;
  logic [3:0]    resp_idx;
  logic          first_wait;

  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          srst_q;
  logic          drop_q;

  logic [3:0]    nib;
  logic [7:0]    resp_byte;
  logic          resp_last;
  logic          bus_done;

  // Response byte: either "!\n" or eight hex digits (MSB first) plus "\n".
  always_comb begin
    nib = 4'h0;
    case (resp_idx[2:0])
      3'd0:    nib = rd_data[31:28];
      3'd1:    nib = rd_data[27:24];
      3'd2:    nib = rd_data[23:20];
      3'd3:    nib = rd_data[19:16];
      3'd4:    nib = rd_data[15:12];
      3'd5:    nib = rd_data[11:8];
      3'd6:    nib = rd_data[7:4];
      default: nib = rd_data[3:0];
    endcase

    resp_byte = 8'h0A;
    if (resp_err) begin
      resp_byte = (resp_idx == 4'd0) ? 8'h21 : 8'h0A;
    end else if (!resp_idx[3]) begin
      resp_byte = (nib < 4'd10) ? {4'h3, nib} : (8'h57 + {4'h0, nib});
    end

    resp_last = resp_err ? (resp_idx == 4'd1) : (resp_idx == 4'd8);
  end

  // ack/err win over a timeout that expires on the same edge.
  assign bus_done = wb.wb_ack_i || wb.wb_err_i || (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      tmo_cnt    <= '0;
      srst_cnt   <= '0;
      rd_data    <= '0;
      resp_err   <= 1'b0;
      resp_idx   <= '0;
      first_wait <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      srst_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      drop_q     <= cmd_valid_i && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            case (cmd_i[33:32])
              OP_A: addr <= cmd_i[31:0];
              OP_R, OP_W: begin
                state   <= S_BUS;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= (cmd_i[33:32] == OP_W);
                adr_q   <= addr;
                dat_q   <= cmd_i[31:0];
                sel_q   <= 4'hF;
                tmo_cnt <= '0;
              end
              default: begin
                state    <= S_SRST;
                srst_q   <= 1'b1;
                srst_cnt <= SRST_LOAD;
                addr     <= '0;
              end
            endcase
          end
        end

        S_BUS: begin
          if (bus_done) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= 4'h0;
            if (wb.wb_err_i || !wb.wb_ack_i) begin
              resp_err <= 1'b1;
              resp_idx <= '0;
              state    <= S_RESP_LOAD;
            end else begin
              addr <= addr + STEP;
              if (we_q) begin
                state <= S_IDLE;
              end else begin
                rd_data  <= wb.wb_dat_i;
                resp_err <= 1'b0;
                resp_idx <= '0;
                state    <= S_RESP_LOAD;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_RESP_LOAD: begin
          if (!tx_busy_i) begin
            tx_data_q  <= resp_byte;
            tx_start_q <= 1'b1;
            first_wait <= 1'b1;
            state      <= S_RESP_WAIT;
          end
        end

        // The transmitter raises busy one cycle after the start pulse, so
        // the first cycle here must not be mistaken for "already done".
        S_RESP_WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (!tx_busy_i) begin
            if (resp_last) begin
              state <= S_IDLE;
            end else begin
              resp_idx <= resp_idx + 4'd1;
              state    <= S_RESP_LOAD;
            end
          end
        end

        S_SRST: begin
          if (srst_cnt == '0) begin
            srst_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            srst_cnt <= srst_cnt - SW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign cmd_drop_o  = drop_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign srst_o      = srst_q;

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Scoreboard bench for wb_cmd_sequencer: stimulus pushes expected bus
// cycles, transmitted bytes and soft-reset pulses into queues; independent
// monitors pop and compare when the DUT presents them.
module tb_wb_cmd_sequencer;

  localparam int TMO  = 8;
  localparam int SRST = 16;
  localparam int STEP = 4;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_A = 2'b10;
  localparam logic [1:0] OP_S = 2'b11;

  // slave response kinds
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] cmd;
  logic        cmd_valid;
  logic        cmd_drop;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        srst;

  wb_cmd_sequencer_if wb ();

  wb_cmd_sequencer #(.ADDR_STEP(STEP), .TIMEOUT(TMO), .SRST_CYCLES(SRST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_i      (cmd),
    .cmd_valid_i(cmd_valid),
    .cmd_drop_o (cmd_drop),
    .busy_o     (busy),
    .wb         (wb),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy),
    .srst_o     (srst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          len;
  } bus_exp_t;

  bus_exp_t    exp_bus_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_srst_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  int seen_drops = 0;

  logic [31:0] m_addr;

  int          slv_kind = K_ACK;
  int          slv_wait = 0;
  logic [31:0] slv_data = '0;
  int          slv_cnt = 0;

  logic        tx_pend = 1'b0;
  int          tx_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      wb.wb_dat_i = $urandom;
      if (wb.wb_stb_o) begin
        if (slv_cnt == slv_wait && slv_kind != K_NONE) begin
          wb.wb_ack_i = (slv_kind == K_ACK) || (slv_kind == K_BOTH);
          wb.wb_err_i = (slv_kind == K_ERR) || (slv_kind == K_BOTH);
          if (wb.wb_ack_i) wb.wb_dat_i = slv_data;
        end
        slv_cnt++;
      end else begin
        slv_cnt = 0;
      end
    end
  end

  // ---------------- transmitter model ----------------
  // busy rises one cycle after the start pulse and stays high 1..4 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_pend) begin
        tx_busy = 1'b1;
        tx_left = $urandom_range(1, 4);
        tx_pend = 1'b0;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) tx_busy = 1'b0;
      end
      if (tx_start) tx_pend = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  initial begin : mon_bus
    bit       prev;
    int       len;
    bus_exp_t cur;
    prev = 0;
    len = 0;
    cur = '{adr: '0, we: 1'b0, dat: '0, len: 0};
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = 0;
        len = 0;
      end else begin
        if (wb.wb_stb_o && !prev) begin
          chk("bus_expected", exp_bus_q.size() != 0, 1);
          if (exp_bus_q.size() != 0) begin
            cur = exp_bus_q.pop_front();
            chk("bus_adr", wb.wb_adr_o, cur.adr);
            chk("bus_we", wb.wb_we_o, cur.we);
            chk("bus_dat", wb.wb_dat_o, cur.dat);
            chk("bus_sel", wb.wb_sel_o, 4'hF);
            chk("bus_cyc", wb.wb_cyc_o, 1);
          end
        end
        if (wb.wb_stb_o) len++;
        if (!wb.wb_stb_o && prev) begin
          chk("stb_len", len, cur.len);
          chk("cyc_after", wb.wb_cyc_o, 0);
          chk("sel_after", wb.wb_sel_o, 0);
          len = 0;
        end
        prev = wb.wb_stb_o;
      end
    end
  end

  initial begin : mon_tx
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && tx_start) begin
        chk("tx_start_while_busy", {tx_pend, tx_busy}, 0);
        chk("tx_expected", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) begin
          e = exp_tx_q.pop_front();
          chk("tx_byte", tx_data, e);
        end
      end
    end
  end

  initial begin : mon_srst
    int  len;
    bit  cyc_seen;
    int  e;
    len = 0;
    cyc_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        len = 0;
        cyc_seen = 0;
      end else if (srst) begin
        len++;
        if (wb.wb_cyc_o) cyc_seen = 1;
      end else if (len > 0) begin
        chk("srst_expected", exp_srst_q.size() != 0, 1);
        if (exp_srst_q.size() != 0) begin
          e = exp_srst_q.pop_front();
          chk("srst_len", len, e);
        end
        chk("cyc_during_srst", cyc_seen, 0);
        len = 0;
        cyc_seen = 0;
      end
    end
  end

  initial begin : mon_drop
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && cmd_drop) seen_drops++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + reference model ----------------
  task automatic pulse_cmd(input logic [1:0] op, input logic [31:0] arg);
    @(negedge clk);
    cmd = {op, arg};
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = '0;
  endtask

  // Expected behaviour from the command rules, then issue the command.
  task automatic issue(input logic [1:0] op, input logic [31:0] arg,
                       input int kind, input int wt, input logic [31:0] rdata);
    string s;
    bus_exp_t e;
    slv_kind = kind;
    slv_wait = wt;
    slv_data = rdata;
    case (op)
      OP_A: m_addr = arg;
      OP_S: begin
        exp_srst_q.push_back(SRST);
        m_addr = '0;
      end
      default: begin
        e.adr = m_addr;
        e.we  = (op == OP_W);
        e.dat = arg;
        e.len = (kind == K_NONE) ? TMO + 1 : wt + 1;
        exp_bus_q.push_back(e);
        if (kind == K_ACK) begin
          m_addr = m_addr + STEP;
          if (op == OP_R) begin
            s = $sformatf("%08h", rdata);
            for (int i = 0; i < 8; i++) exp_tx_q.push_back(s[i]);
            exp_tx_q.push_back(8'h0A);
          end
        end else begin
          exp_tx_q.push_back(8'h21);
          exp_tx_q.push_back(8'h0A);
        end
      end
    endcase
    pulse_cmd(op, arg);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] arg,
                     input int kind, input int wt, input logic [31:0] rdata);
    issue(op, arg, kind, wt, rdata);
    wait_idle();
  endtask

  // Issue a command, then another one 'dly' cycles after the first was
  // sampled; the second lands while the sequencer is still busy.
  task automatic run_with_drop(input logic [1:0] op, input logic [31:0] arg,
                               input int kind, input int wt, input int dly);
    issue(op, arg, kind, wt, $urandom);
    repeat (dly - 1) @(negedge clk);
    cmd = {OP_A, 32'h5555_0000};
    cmd_valid = 1'b1;
    exp_drops++;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = '0;
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cyc"}, wb.wb_cyc_o, 0);
    chk({tag, "_stb"}, wb.wb_stb_o, 0);
    chk({tag, "_we"}, wb.wb_we_o, 0);
    chk({tag, "_adr"}, wb.wb_adr_o, 0);
    chk({tag, "_dat"}, wb.wb_dat_o, 0);
    chk({tag, "_sel"}, wb.wb_sel_o, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_txs"}, tx_start, 0);
    chk({tag, "_srst"}, srst, 0);
    chk({tag, "_drop"}, cmd_drop, 0);
  endtask

  task automatic reset_now(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    exp_bus_q.delete();
    exp_tx_q.delete();
    exp_srst_q.delete();
    m_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin : stim
    logic [1:0]  op;
    int          r;
    int          kind;
    logic [31:0] arg;
    rst_n = 1'b0;
    cmd = '0;
    cmd_valid = 1'b0;
    m_addr = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed cases
    run(OP_A, 32'h0000_1000, K_ACK, 0, '0);
    run(OP_W, 32'hDEAD_BEEF, K_ACK, 2, '0);
    run(OP_A, 32'h0000_1000, K_ACK, 0, '0);
    run(OP_R, 32'h0, K_ACK, 1, 32'h0123_ABCD);
    run(OP_R, 32'h0, K_NONE, 0, '0);
    run(OP_W, 32'h1111_2222, K_ACK, 0, '0);
    run(OP_S, 32'h0, K_ACK, 0, '0);
    run(OP_R, 32'h0, K_ACK, 0, 32'hFEDC_BA98);
    run(OP_A, 32'hFFFF_FFFC, K_ACK, 0, '0);
    run(OP_W, 32'hA5A5_0001, K_ACK, 1, '0);
    run_with_drop(OP_W, 32'hA5A5_0002, K_ACK, 3, 1);
    run(OP_R, 32'h0, K_ERR, 2, 32'h1234_5678);
    run(OP_W, 32'h0BAD_0BAD, K_BOTH, 1, '0);
    run(OP_R, 32'h0, K_ACK, 3, 32'h89AB_CDEF);
    // second command sampled on the edge that returns to idle
    run_with_drop(OP_W, 32'h7777_0000, K_ACK, 2, 3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 2) ? OP_A : (r < 6) ? OP_R : (r < 9) ? OP_W : OP_S;
      r = $urandom_range(0, 5);
      kind = (r < 3) ? K_ACK : (r == 3) ? K_ERR : (r == 4) ? K_NONE : K_BOTH;
      arg = $urandom;
      if (op == OP_A && arg[0]) arg = 32'hFFFF_FFF0 | {28'h0, arg[3:2], 2'b00};
      if (i % 7 == 3)
        run_with_drop((op == OP_A) ? OP_W : op, arg, kind, $urandom_range(0, 3), 1);
      else
        run(op, arg, kind, $urandom_range(0, 3), $urandom);
    end

    // reset in the middle of a bus cycle, then in the middle of a response
    issue(OP_R, 32'h0, K_NONE, 0, '0);
    repeat (3) @(negedge clk);
    reset_now("rst_bus");
    run(OP_R, 32'h0, K_ACK, 1, 32'h0000_00F1);
    issue(OP_R, 32'h0, K_ACK, 0, 32'hC0FF_EE00);
    repeat (8) @(negedge clk);
    reset_now("rst_resp");
    run(OP_R, 32'h0, K_ACK, 0, 32'h2468_ACE0);
    run(OP_R, 32'h0, K_ACK, 2, 32'h1357_9BDF);

    repeat (10) @(negedge clk);
    chk("drop_count", seen_drops, exp_drops);
    chk("bus_q_empty", exp_bus_q.size(), 0);
    chk("tx_q_empty", exp_tx_q.size(), 0);
    chk("srst_q_empty", exp_srst_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_cmd_sequencer.md
Name: wb_cmd_sequencer

Overview:
Executes the 34-bit command words produced by the UART command decoder as Wishbone classic master cycles. It holds the current bus address and runs single read and write transfers with a timeout. Read results and error indications go back to the host as ASCII bytes through the UART transmitter handshake. It sits between the UART-to-command decoder and the on-chip Wishbone interconnect, and also generates the soft-reset pulse for the rest of the design.

Parameters:
ADDR_STEP, 4, address increment after each successful R or W; 0 disables auto-increment
TIMEOUT, 255, max cycles waiting for wb_ack_i/wb_err_i before abort (counter width $clog2(TIMEOUT+1))
SRST_CYCLES, 16, length of srst_o pulse in clk cycles (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_i  in  34  command word: [33:32] opcode (00 R, 01 W, 10 A, 11 S), [31:0] argument
cmd_valid_i  in  1  single-cycle strobe, cmd_i valid
cmd_drop_o  out  1  1-cycle pulse: command arrived while not IDLE and was discarded
busy_o  out  1  high whenever state != IDLE
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  32  byte address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects, constant 4'hF during cycles, 0 otherwise
wb_dat_i  in  32  read data
wb_ack_i  in  1  transfer acknowledge
wb_err_i  in  1  transfer error
tx_data_o  out  8  byte to UART transmitter
tx_start_o  out  1  1-cycle pulse, load tx_data_o
tx_busy_i  in  1  UART transmitter busy
srst_o  out  1  soft-reset output, active-high

Behaviour:
- Reset (rst_n low, async): state IDLE; addr reg = 0; all outputs 0. Reset mid-transfer drops cyc/stb immediately and loses any pending response.
- States: IDLE, BUS, RESP_LOAD, RESP_WAIT, SRST.
- IDLE + cmd_valid_i:
  - op A: addr = cmd_i[31:0]; stay IDLE; no bus activity.
  - op W: next cycle enter BUS with cyc=stb=we=1, adr=addr, dat_o=cmd_i[31:0].
  - op R: same as W with we=0.
  - op S: enter SRST; srst_o=1 for exactly SRST_CYCLES cycles; addr cleared to 0; then IDLE.
- BUS: cyc/stb held until the edge that samples ack or err; both low the following cycle (no pipelined/burst mode). Timeout counter starts at 0 on BUS entry; if no ack/err is seen by count==TIMEOUT, abort as err.
  - ack, R: latch wb_dat_i; response = 8 lowercase hex chars MSB nibble first, then 0x0A.
  - ack, W: no response; go IDLE.
  - err or timeout (R or W): response = "!" (0x21), 0x0A; addr unchanged.
  - ack and err in the same cycle: treated as err.
- Successful ack only: addr += ADDR_STEP, modulo 2^32 (wraps FFFFFFFC -> 00000000).
- RESP_LOAD: if !tx_busy_i, drive tx_data_o, pulse tx_start_o once, go RESP_WAIT. RESP_WAIT ignores tx_busy_i for the first cycle after the start pulse, then waits for tx_busy_i low. It then loads the next byte, or goes to IDLE after the last byte. tx_data_o holds its value until the next load.
- cmd_valid_i while busy_o=1: command ignored, cmd_drop_o pulses next cycle. A command arriving in the same cycle as the return to IDLE is also dropped (busy_o is still 1).
- Latency: cmd_valid_i at edge N -> wb_stb_o high after edge N. Zero-wait slave (ack at first sampled edge) gives a 1-cycle stb.

Test Plan:
- A 0x00001000, then W 0xDEADBEEF, slave acks after 2 wait states -> one write cycle, adr=0x1000, dat=0xDEADBEEF, sel=F, stb high 3 cycles; addr becomes 0x1004.
- A 0x1000, R with slave returning 0x0123ABCD -> tx bytes "0123abcd\n" in order, one tx_start per byte, each start issued only after tx_busy_i falls; addr becomes 0x1004.
- R to a slave that never acks (TIMEOUT=8) -> stb drops after 9 cycles; tx sends 0x21, 0x0A; addr unchanged.
- S command, SRST_CYCLES=16 -> srst_o high exactly 16 cycles, no wb_cyc_o, next R uses adr 0.
- A 0xFFFFFFFC, W then W -> second write at adr 0x00000000; cmd_valid_i pulsed during a BUS state -> cmd_drop_o pulse, no extra cycle.
- rst_n low in mid-BUS and in mid-RESP -> all outputs 0 asynchronously; after release, an R to 0 executes normally.
